var_int_encoder: RTL and testbench
==================================

// Module: var_int_encoder
// PURPOSE
//  QUIC variable-length integer encoder (RFC 9000 sec 16, A.1 inverse). Accepts one
//  62-bit value per handshake, picks the encoded length (minimal, or forced larger),
//  and streams the encoding MSB-first, one byte per cycle, with valid/ready.
//  Sits in the QUIC TX path, feeding frame/packet header assembly.
// PARAMETERS
//  LEN_W  4  width of len output (holds 1..8)
// PORTS
//  clk         in   1   clock; all logic on posedge
//  rst         in   1   reset, asynchronous, active-high
//  in_valid    in   1   in_value/in_len_sel valid
//  in_ready    out  1   encoder can accept a value this cycle
//  in_value    in   64  integer to encode; legal range 0..2^62-1
//  in_len_sel  in   2   minimum length code: 0=1B 1=2B 2=4B 3=8B
//  out_valid   out  1   out_data holds an encoded byte
//  out_ready   in   1   downstream accepts out_data this cycle
//  out_data    out  8   encoded byte, MSB-first
//  out_last    out  1   out_data is final byte of this integer
//  len         out  LEN_W  byte count of integer being sent; stable while out_valid
//  err         out  1   one-cycle pulse: accepted value >= 2^62, dropped
// BEHAVIOUR
//  Reset (async): state=IDLE, out_valid=0, out_last=0, out_data=0, len=0, err=0,
//   shift reg/byte counter=0. in_ready=1 once rst deasserts.
//  Accept = in_valid & in_ready. Output byte transfer = out_valid & out_ready.
//  Min length: v<2^6 ->1; v<2^14 ->2; v<2^30 ->4; else 8.
//  Effective L = max(min length, 1<<in_len_sel). Prefix = log2(L) in 2 MSBs.
//  Encoded word = {prefix[1:0], in_value[8L-3:0]}, left-aligned in 64-bit shift reg.
//  States: IDLE, SEND.
//   IDLE: in_ready=1, out_valid=0. On accept with legal value: load shift reg,
//    cnt=L-1, len=L, -> SEND. Illegal value (in_value[63:62]!=0): err=1 next cycle,
//    stay IDLE, no output bytes.
//   SEND: out_valid=1, out_data=shift[63:56], out_last=(cnt==0).
//    Transfer & !out_last: shift<<=8, cnt-=1.
//    Transfer & out_last: in_ready=1 this cycle (comb); if accept, load new value
//     and stay SEND (zero bubble); else -> IDLE, out_valid=0, len=0.
//    No transfer: all outputs held stable (AXI-style; out_data/out_last/len frozen).
//   in_ready=0 in SEND except final-byte transfer cycle.
//  Latency: accept at cycle N -> first byte out_valid at N+1; L-byte integer
//   occupies exactly L cycles with out_ready held high.
//  Illegal value accepted on the final-byte cycle: err pulses, -> IDLE.
//  err independent of out_* stream; never asserted with no accept on prior cycle.
//  in_len_sel only sampled on accept; smaller than min length is ignored (never truncates).
//  rst mid-SEND: frame abandoned, outputs to reset values immediately; no resume.
//  out_valid never drops without out_last transfer except by rst.
// TESTING
//  1) 37, sel=0 -> 0x25, out_last=1, len=1, first byte cycle after accept.
//  2) 15293, sel=0 -> 0x7B 0xBD, len=2; 494878333 -> 0x9D 0x7F 0x3E 0x7D, len=4.
//  3) 151288809941952652 -> C2 19 7C 5E FF 14 E8 8C, len=8; then 37 with sel=1
//     offered on last-byte cycle -> 0x40 0x25 with no idle cycle between.
//  4) 494878333 with out_ready toggled randomly -> same 4 bytes, data stable while stalled.
//  5) 2^62 and 2^64-1 -> err single-cycle pulse, no out_valid; next 0 -> 0x00.
//  6) rst asserted after 3rd byte of 8-byte value -> out_valid=0 same cycle,
//     post-reset 63 -> 0x3F only; boundaries 63/64/16383/16384/2^30-1/2^30 give len 1/2/2/4/4/8.

Source files
------------

// File: rtl/var_int_encoder_if.sv
// Handshake bundle for the QUIC varint encoder: value input stream and byte output stream.
interface var_int_encoder_if #(
  parameter int unsigned LEN_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [63:0]      in_value;
  logic [1:0]       in_len_sel;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_data;
  logic             out_last;
  logic [LEN_W-1:0] len;
  logic             err;

  modport master (
    output in_valid, in_value, in_len_sel, out_ready,
    input  in_ready, out_valid, out_data, out_last, len, err
  );

  modport slave (
    input  in_valid, in_value, in_len_sel, out_ready,
    output in_ready, out_valid, out_data, out_last, len, err
  );
endinterface

// File: rtl/var_int_encoder.sv
// QUIC variable-length integer encoder: one 62-bit value in, 1/2/4/8 bytes out MSB-first.
module var_int_encoder #(
  parameter int unsigned LEN_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  var_int_encoder_if.slave  bus
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t           state_q, state_d;
  logic [63:0]      shift_q, shift_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             err_q, err_d;

  logic [1:0]       min_code;
  logic [1:0]       eff_code;
  logic [63:0]      load_shift;
  logic [2:0]       load_cnt;
  logic [LEN_W-1:0] load_len;
  logic             illegal;
  logic             last_xfer;
  logic             in_ready_c;
  logic             accept;

  // Length code of the incoming value: minimal code, raised to the requested one.
  always_comb begin
    min_code = 2'd0;
    if (bus.in_value[61:30] != '0)      min_code = 2'd3;
    else if (bus.in_value[29:14] != '0) min_code = 2'd2;
    else if (bus.in_value[13:6] != '0)  min_code = 2'd1;
    eff_code = (bus.in_len_sel > min_code) ? bus.in_len_sel : min_code;
  end

  // Encoded word left-aligned so the first byte to send sits in the top octet.
  always_comb begin
    load_shift = '0;
    load_cnt   = 3'd0;
    unique case (eff_code)
      2'd0: begin
        load_shift = {2'b00, bus.in_value[5:0], 56'd0};
        load_cnt   = 3'd0;
      end
      2'd1: begin
        load_shift = {2'b01, bus.in_value[13:0], 48'd0};
        load_cnt   = 3'd1;
      end
      2'd2: begin
        load_shift = {2'b10, bus.in_value[29:0], 32'd0};
        load_cnt   = 3'd3;
      end
      default: begin
        load_shift = {2'b11, bus.in_value[61:0]};
        load_cnt   = 3'd7;
      end
    endcase
    load_len = LEN_W'(1) << eff_code;
  end

  assign illegal    = |bus.in_value[63:62];
  assign last_xfer  = (state_q == SEND) && bus.out_ready && (cnt_q == 3'd0);
  assign in_ready_c = !rst && ((state_q == IDLE) || last_xfer);
  assign accept     = bus.in_valid && in_ready_c;

  // Next-state: load on legal accept, shift on non-final transfer, drain to IDLE otherwise.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (illegal) begin
            err_d = 1'b1;
          end else begin
            state_d = SEND;
            shift_d = load_shift;
            cnt_d   = load_cnt;
            len_d   = load_len;
          end
        end
      end
      SEND: begin
        if (bus.out_ready) begin
          if (cnt_q != 3'd0) begin
            shift_d = {shift_q[55:0], 8'd0};
            cnt_d   = cnt_q - 3'd1;
          end else if (accept && !illegal) begin
            shift_d = load_shift;
            cnt_d   = load_cnt;
            len_d   = load_len;
          end else begin
            state_d = IDLE;
            shift_d = '0;
            cnt_d   = 3'd0;
            len_d   = '0;
            err_d   = accept;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= 3'd0;
      len_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      err_q   <= err_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = (state_q == SEND);
  assign bus.out_data  = shift_q[63:56];
  assign bus.out_last  = (state_q == SEND) && (cnt_q == 3'd0);
  assign bus.len       = len_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_var_int_encoder.sv
// Scoreboard bench for var_int_encoder: expected bytes queued at accept, popped on each transfer.
module tb_var_int_encoder;

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic [3:0] len;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   pass_cnt = 0;
  int   tot_cnt  = 0;
  int   cyc      = 0;
  int   xfer_cnt = 0;
  int   last_xfer_edge = 0;
  exp_t sb[$];

  var_int_encoder_if #(.LEN_W(4)) bus ();

  var_int_encoder #(.LEN_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Transfer monitor: one scoreboard comparison per accepted output byte.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      xfer_cnt       = xfer_cnt + 1;
      last_xfer_edge = cyc + 1;
      tot_cnt        = tot_cnt + 1;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_byte: got data=%02h last=%0b len=%0d, required no output",
                 bus.out_data, bus.out_last, bus.len);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ({bus.out_data, bus.out_last, bus.len} !== {e.data, e.last, e.len})
          $display("FAIL byte: got data=%02h last=%0b len=%0d, required data=%02h last=%0b len=%0d",
                   bus.out_data, bus.out_last, bus.len, e.data, e.last, e.len);
        else
          pass_cnt = pass_cnt + 1;
      end
    end
  end

  function automatic void push_byte(logic [7:0] d, logic l, logic [3:0] n);
    exp_t e;
    e.data = d;
    e.last = l;
    e.len  = n;
    sb.push_back(e);
  endfunction

  // Reference encoder built from numeric thresholds and a right-shift byte extraction.
  function automatic void push_model(logic [63:0] v, logic [1:0] sel);
    int unsigned nb;
    logic [63:0] word;
    logic [1:0]  prefix;
    if (v < 64'd64)                nb = 1;
    else if (v < 64'd16384)        nb = 2;
    else if (v < 64'd1073741824)   nb = 4;
    else                           nb = 8;
    if ((32'd1 << sel) > nb) nb = 32'd1 << sel;
    prefix = (nb == 1) ? 2'd0 : (nb == 2) ? 2'd1 : (nb == 4) ? 2'd2 : 2'd3;
    word = v | (64'(prefix) << (8 * nb - 2));
    for (int i = 0; i < int'(nb); i++)
      push_byte(8'(word >> (8 * (int'(nb) - 1 - i))), (i == int'(nb) - 1), 4'(nb));
  endfunction

  task automatic send(input logic [63:0] v, input logic [1:0] sel, output int acc);
    bit got;
    got = 1'b0;
    acc = -1;
    bus.in_valid   = 1'b1;
    bus.in_value   = v;
    bus.in_len_sel = sel;
    for (int n = 0; n < 300 && !got; n++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        acc = cyc + 1;
        got = 1'b1;
      end
    end
    if (!got) begin
      tot_cnt = tot_cnt + 1;
      $display("FAIL accept_timeout: in_ready=%0b, required 1 within 300 cycles", bus.in_ready);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int n = 0; n < 300 && !done; n++) begin
      @(negedge clk);
      if (sb.size() == 0 && !bus.out_valid) done = 1'b1;
    end
    tot_cnt = tot_cnt + 1;
    if (!done) begin
      $display("FAIL drain_timeout: %0d bytes outstanding, required 0", sb.size());
      sb.delete();
    end else begin
      pass_cnt = pass_cnt + 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.in_valid   = 1'b0;
    bus.in_value   = '0;
    bus.in_len_sel = 2'd0;
    bus.out_ready  = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tot_cnt = tot_cnt + 1;
    if ({bus.out_valid, bus.out_last, bus.out_data, bus.len, bus.err} !== 15'd0)
      $display("FAIL reset_outputs: got valid=%0b last=%0b data=%02h len=%0d err=%0b, required all 0",
               bus.out_valid, bus.out_last, bus.out_data, bus.len, bus.err);
    else pass_cnt = pass_cnt + 1;
    rst = 1'b0;
    #1;
    tot_cnt = tot_cnt + 1;
    if (bus.in_ready !== 1'b1)
      $display("FAIL reset_in_ready: got %0b, required 1", bus.in_ready);
    else pass_cnt = pass_cnt + 1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_byte();
    int acc;
    push_byte(8'h25, 1'b1, 4'd1);
    send(64'd37, 2'd0, acc);
    @(negedge clk);
    tot_cnt = tot_cnt + 1;
    if (bus.out_valid !== 1'b1)
      $display("FAIL first_byte_latency: out_valid=%0b, required 1", bus.out_valid);
    else pass_cnt = pass_cnt + 1;
    drain();
    tot_cnt = tot_cnt + 1;
    if (last_xfer_edge - acc !== 1)
      $display("FAIL single_byte_span: got %0d cycles, required 1", last_xfer_edge - acc);
    else pass_cnt = pass_cnt + 1;
  endtask

  task automatic test_two_four();
    int acc;
    push_byte(8'h7B, 1'b0, 4'd2);
    push_byte(8'hBD, 1'b1, 4'd2);
    send(64'd15293, 2'd0, acc);
    drain();
    tot_cnt = tot_cnt + 1;
    if (last_xfer_edge - acc !== 2)
      $display("FAIL two_byte_span: got %0d cycles, required 2", last_xfer_edge - acc);
    else pass_cnt = pass_cnt + 1;
    push_byte(8'h9D, 1'b0, 4'd4);
    push_byte(8'h7F, 1'b0, 4'd4);
    push_byte(8'h3E, 1'b0, 4'd4);
    push_byte(8'h7D, 1'b1, 4'd4);
    send(64'd494878333, 2'd0, acc);
    drain();
    tot_cnt = tot_cnt + 1;
    if (last_xfer_edge - acc !== 4)
      $display("FAIL four_byte_span: got %0d cycles, required 4", last_xfer_edge - acc);
    else pass_cnt = pass_cnt + 1;
  endtask

  task automatic test_back_to_back();
    int acc0;
    int acc1;
    logic [7:0] exp8 [8];
    exp8 = '{8'hC2, 8'h19, 8'h7C, 8'h5E, 8'hFF, 8'h14, 8'hE8, 8'h8C};
    for (int i = 0; i < 8; i++) push_byte(exp8[i], (i == 7), 4'd8);
    push_byte(8'h40, 1'b0, 4'd2);
    push_byte(8'h25, 1'b1, 4'd2);
    send(64'd151288809941952652, 2'd0, acc0);
    send(64'd37, 2'd1, acc1);
    tot_cnt = tot_cnt + 1;
    if (acc1 - acc0 !== 8)
      $display("FAIL b2b_accept: second accept %0d cycles after first, required 8", acc1 - acc0);
    else pass_cnt = pass_cnt + 1;
    drain();
    tot_cnt = tot_cnt + 1;
    if (last_xfer_edge - acc0 !== 10)
      $display("FAIL b2b_span: got %0d cycles, required 10", last_xfer_edge - acc0);
    else pass_cnt = pass_cnt + 1;
  endtask

  task automatic test_stall();
    int acc;
    bit held;
    bit done;
    logic [12:0] snap;
    held = 1'b0;
    done = 1'b0;
    snap = '0;
    push_model(64'd494878333, 2'd0);
    bus.out_ready = 1'b0;
    send(64'd494878333, 2'd0, acc);
    for (int i = 0; i < 200 && !done; i++) begin
      @(posedge clk);
      #1;
      bus.out_ready = (i < 2) ? 1'b0 : 1'($urandom_range(0, 1));
      @(negedge clk);
      if (held && bus.out_valid) begin
        tot_cnt = tot_cnt + 1;
        if ({bus.out_data, bus.out_last, bus.len} !== snap)
          $display("FAIL stall_hold: got %04h, required %04h",
                   {bus.out_data, bus.out_last, bus.len}, snap);
        else pass_cnt = pass_cnt + 1;
      end
      held = bus.out_valid && !bus.out_ready;
      snap = {bus.out_data, bus.out_last, bus.len};
      if (sb.size() == 0 && !bus.out_valid) done = 1'b1;
    end
    bus.out_ready = 1'b1;
    drain();
  endtask

  task automatic test_illegal();
    int acc;
    int acc1;
    logic [63:0] bad [2];
    bad = '{64'h4000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF};
    for (int k = 0; k < 2; k++) begin
      send(bad[k], 2'd0, acc);
      @(negedge clk);
      tot_cnt = tot_cnt + 1;
      if (bus.err !== 1'b1 || bus.out_valid !== 1'b0)
        $display("FAIL illegal_err_%0d: err=%0b out_valid=%0b, required err=1 out_valid=0",
                 k, bus.err, bus.out_valid);
      else pass_cnt = pass_cnt + 1;
      @(negedge clk);
      tot_cnt = tot_cnt + 1;
      if (bus.err !== 1'b0)
        $display("FAIL illegal_pulse_%0d: err=%0b, required 0", k, bus.err);
      else pass_cnt = pass_cnt + 1;
      @(posedge clk);
      #1;
    end
    push_byte(8'hC0, 1'b0, 4'd8);
    for (int i = 0; i < 6; i++) push_byte(8'h00, 1'b0, 4'd8);
    push_byte(8'h25, 1'b1, 4'd8);
    send(64'd37, 2'd3, acc);
    send(64'h4000_0000_0000_0000, 2'd0, acc1);
    @(negedge clk);
    tot_cnt = tot_cnt + 1;
    if (acc1 - acc !== 8 || bus.err !== 1'b1 || bus.out_valid !== 1'b0)
      $display("FAIL illegal_on_last: gap=%0d err=%0b out_valid=%0b, required gap=8 err=1 out_valid=0",
               acc1 - acc, bus.err, bus.out_valid);
    else pass_cnt = pass_cnt + 1;
    drain();
    push_byte(8'h00, 1'b1, 4'd1);
    send(64'd0, 2'd0, acc);
    drain();
  endtask

  task automatic test_rst_mid();
    int acc;
    int x0;
    bit got;
    got = 1'b0;
    push_model(64'd151288809941952652, 2'd0);
    send(64'd151288809941952652, 2'd0, acc);
    x0 = xfer_cnt;
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge clk);
      if (xfer_cnt - x0 >= 3) got = 1'b1;
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    tot_cnt = tot_cnt + 1;
    if (!got || {bus.out_valid, bus.out_last, bus.out_data, bus.len} !== 14'd0)
      $display("FAIL rst_mid: reached=%0b valid=%0b last=%0b data=%02h len=%0d, required reached=1 and all 0",
               got, bus.out_valid, bus.out_last, bus.out_data, bus.len);
    else pass_cnt = pass_cnt + 1;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    push_byte(8'h3F, 1'b1, 4'd1);
    send(64'd63, 2'd0, acc);
    drain();
  endtask

  task automatic test_boundaries();
    int acc;
    logic [63:0] vals [6];
    logic [3:0]  lens [6];
    vals = '{64'd63, 64'd64, 64'd16383, 64'd16384, 64'd1073741823, 64'd1073741824};
    lens = '{4'd1, 4'd2, 4'd2, 4'd4, 4'd4, 4'd8};
    for (int k = 0; k < 6; k++) begin
      push_model(vals[k], 2'd0);
      send(vals[k], 2'd0, acc);
      @(negedge clk);
      tot_cnt = tot_cnt + 1;
      if (bus.len !== lens[k])
        $display("FAIL boundary_len_%0d: got %0d, required %0d", k, bus.len, lens[k]);
      else pass_cnt = pass_cnt + 1;
      drain();
    end
    push_model(64'd5, 2'd2);
    send(64'd5, 2'd2, acc);
    drain();
    push_model(64'd70000, 2'd1);
    send(64'd70000, 2'd1, acc);
    drain();
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_two_four();
    test_back_to_back();
    test_stall();
    test_illegal();
    test_rst_mid();
    test_boundaries();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
